// File: rtl/snitch_mem_model.sv
// Parametrised single-port memory model with byte-strobed writes, configurable read latency and a credit-limited response FIFO.
// Define SNITCH_MEM_MODEL_STALL_EN to gate req_ready_o with a deterministic LFSR stall pattern.
module snitch_mem_model #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned StrbWidth = DataWidth / 8,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned RspDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_data_i,
  input  logic                 req_write_i,
  input  logic [StrbWidth-1:0] req_strb_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i
);

  localparam int unsigned Depth      = 2 ** AddrWidth;
  localparam int unsigned CntWidth   = $clog2(RspDepth + 1);
  localparam int unsigned PtrWidth   = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned PipeStages = ReadLatency - 1;

  logic [DataWidth-1:0] mem_reg [Depth];
  logic [DataWidth-1:0] wr_mask;
  logic [DataWidth-1:0] rd_word;
  logic                 credit_ok;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 push;
  logic                 pop;
  logic [DataWidth-1:0] push_data;

  logic [DataWidth-1:0] fifo_data_reg [RspDepth];
  logic [PtrWidth-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PtrWidth-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CntWidth-1:0]  fifo_cnt_reg, fifo_cnt_next;
  logic [CntWidth-1:0]  out_cnt_reg, out_cnt_next;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(RspDepth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Credits count every read from acceptance to response handshake, so the FIFO can never overflow.
  assign credit_ok = (out_cnt_reg < CntWidth'(RspDepth));

`ifdef SNITCH_MEM_MODEL_STALL_EN
  logic [7:0] lfsr_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_reg <= 8'hA5;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  assign req_ready_o = credit_ok & ~lfsr_reg[0];
`else
  assign req_ready_o = credit_ok;
`endif

  assign wr_acc  = req_valid_i & req_ready_o & req_write_i;
  assign rd_acc  = req_valid_i & req_ready_o & ~req_write_i;
  assign rd_word = mem_reg[req_addr_i];

  for (genvar gi = 0; gi < StrbWidth; gi++) begin : g_strb
    assign wr_mask[gi*8 +: 8] = {8{req_strb_i[gi]}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_acc) begin
      mem_reg[req_addr_i] <= (mem_reg[req_addr_i] & ~wr_mask) | (req_data_i & wr_mask);
    end
  end

  if (ReadLatency == 1) begin : g_no_pipe
    assign push      = rd_acc;
    assign push_data = rd_word;
  end else begin : g_pipe
    logic [PipeStages-1:0] pipe_valid_reg;
    logic [DataWidth-1:0]  pipe_data_reg [PipeStages];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pipe_valid_reg <= '0;
        for (int i = 0; i < PipeStages; i++) begin
          pipe_data_reg[i] <= '0;
        end
      end else begin
        pipe_valid_reg[0] <= rd_acc;
        pipe_data_reg[0]  <= rd_word;
        for (int i = 1; i < PipeStages; i++) begin
          pipe_valid_reg[i] <= pipe_valid_reg[i-1];
          pipe_data_reg[i]  <= pipe_data_reg[i-1];
        end
      end
    end

    assign push      = pipe_valid_reg[PipeStages-1];
    assign push_data = pipe_data_reg[PipeStages-1];
  end

  assign rsp_valid_o = (fifo_cnt_reg != '0);
  assign rsp_data_o  = rsp_valid_o ? fifo_data_reg[rd_ptr_reg] : '0;
  assign pop         = rsp_valid_o & rsp_ready_i;

  always_comb begin
    wr_ptr_next   = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next   = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    fifo_cnt_next = fifo_cnt_reg;
    out_cnt_next  = out_cnt_reg;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + 1'b1;
      2'b01:   fifo_cnt_next = fifo_cnt_reg - 1'b1;
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
    case ({rd_acc, pop})
      2'b10:   out_cnt_next = out_cnt_reg + 1'b1;
      2'b01:   out_cnt_next = out_cnt_reg - 1'b1;
      default: out_cnt_next = out_cnt_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      out_cnt_reg  <= '0;
      for (int i = 0; i < RspDepth; i++) begin
        fifo_data_reg[i] <= '0;
      end
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      fifo_cnt_reg <= fifo_cnt_next;
      out_cnt_reg  <= out_cnt_next;
      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_snitch_mem_model.sv
// Directed bench for snitch_mem_model: three instances (lat1/depth4, lat3/depth4, lat1/depth2).
// With SNITCH_MEM_MODEL_STALL_EN defined the timing-exact sections are replaced by an LFSR stall check.
module tb_snitch_mem_model;

    logic        clk;
    logic        rst;
    logic [9:0]  req_addr [3];
    logic [31:0] req_data [3];
    logic [2:0]  req_write;
    logic [3:0]  req_strb [3];
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [31:0] rsp_data [3];
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        snitch_mem_model #(
            .AddrWidth  (10),
            .DataWidth  (32),
            .ReadLatency((gi == 1) ? 3 : 1),
            .RspDepth   ((gi == 2) ? 2 : 4)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .req_addr_i (req_addr[gi]),
            .req_data_i (req_data[gi]),
            .req_write_i(req_write[gi]),
            .req_strb_i (req_strb[gi]),
            .req_valid_i(req_valid[gi]),
            .req_ready_o(req_ready[gi]),
            .rsp_data_o (rsp_data[gi]),
            .rsp_valid_o(rsp_valid[gi]),
            .rsp_ready_i(rsp_ready[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SNITCH_MEM_MODEL_STALL_EN
    logic [7:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
`endif

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (ok) begin
            $display("PASS %s: observed %0h", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted (bounded), returns just after the accepting edge.
    task automatic do_req(input int idx, input logic wr, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        logic acc;
        acc = 1'b0;
        req_valid[idx] = 1'b1;
        req_write[idx] = wr;
        req_addr[idx]  = a;
        req_data[idx]  = d;
        req_strb[idx]  = s;
        for (int t = 0; t < 64 && !acc; t++) begin
            acc = req_ready[idx];
            tick();
        end
        req_valid[idx] = 1'b0;
        chk("req_accept", acc === 1'b1, acc, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        rsp_ready = 3'b111;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = '0;
            req_data[i] = '0;
            req_strb[i] = '0;
        end
        tick();
        tick();

        for (int i = 0; i < 3; i++) begin
            chk("rst_rsp_valid", rsp_valid[i] === 1'b0, rsp_valid[i], 1'b0);
            chk("rst_rsp_data", rsp_data[i] === 32'h0, rsp_data[i], 32'h0);
`ifndef SNITCH_MEM_MODEL_STALL_EN
            chk("rst_req_ready", req_ready[i] === 1'b1, req_ready[i], 1'b1);
`endif
        end
        rst = 1'b0;

        do_req(0, 1'b0, 10'd0, 32'h0, 4'h0);
        chk("rd0_valid", rsp_valid[0] === 1'b1, rsp_valid[0], 1'b1);
        chk("rd0_data", rsp_data[0] === 32'h0, rsp_data[0], 32'h0);
        tick();
        chk("rd0_popped", rsp_valid[0] === 1'b0, rsp_valid[0], 1'b0);

        do_req(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
        chk("wr_no_rsp", rsp_valid[0] === 1'b0, rsp_valid[0], 1'b0);
        do_req(0, 1'b1, 10'd5, 32'h11223344, 4'b0101);
        do_req(0, 1'b0, 10'd5, 32'h0, 4'h0);
        chk("strb_valid", rsp_valid[0] === 1'b1, rsp_valid[0], 1'b1);
        chk("strb_data", rsp_data[0] === 32'hDE22BE44, rsp_data[0], 32'hDE22BE44);
        tick();
        do_req(0, 1'b1, 10'd5, 32'hFFFFFFFF, 4'h0);
        do_req(0, 1'b0, 10'd5, 32'h0, 4'h0);
        chk("strb_none_data", rsp_data[0] === 32'hDE22BE44, rsp_data[0], 32'hDE22BE44);
        tick();
        do_req(0, 1'b1, 10'd1023, 32'hABCDEF01, 4'b1000);
        do_req(0, 1'b0, 10'd1023, 32'h0, 4'h0);
        chk("top_addr_data", rsp_data[0] === 32'hAB000000, rsp_data[0], 32'hAB000000);
        tick();
        do_req(0, 1'b0, 10'd6, 32'h0, 4'h0);
        chk("neighbour_data", rsp_data[0] === 32'h0, rsp_data[0], 32'h0);
        tick();

`ifdef SNITCH_MEM_MODEL_STALL_EN
        begin
            int   a;
            int   exp_rd;
            logic prev_acc;
            for (int i = 0; i < 64; i++) begin
                do_req(0, 1'b1, 10'(16 + i), 32'h1000 + 32'(i), 4'hF);
            end
            tick();
            a = 0;
            exp_rd = 0;
            prev_acc = 1'b0;
            for (int c = 0; c < 64; c++) begin
                chk("stall_ready", req_ready[0] === ~m_lfsr[0], req_ready[0], ~m_lfsr[0]);
                if (prev_acc) begin
                    chk("stall_rsp_valid", rsp_valid[0] === 1'b1, rsp_valid[0], 1'b1);
                    chk("stall_rsp_data", rsp_data[0] === 32'h1000 + 32'(exp_rd),
                        rsp_data[0], 32'h1000 + 32'(exp_rd));
                    exp_rd++;
                end else begin
                    chk("stall_rsp_idle", rsp_valid[0] === 1'b0, rsp_valid[0], 1'b0);
                end
                req_valid[0] = 1'b1;
                req_write[0] = 1'b0;
                req_addr[0]  = 10'(16 + a);
                prev_acc = req_ready[0];
                tick();
                if (prev_acc) a++;
            end
            req_valid[0] = 1'b0;
            if (prev_acc) begin
                chk("stall_last_data", rsp_data[0] === 32'h1000 + 32'(exp_rd),
                    rsp_data[0], 32'h1000 + 32'(exp_rd));
                exp_rd++;
            end
            chk("stall_all_returned", exp_rd == a, 32'(exp_rd), 32'(a));
        end
`else
        for (int i = 1; i <= 4; i++) begin
            do_req(1, 1'b1, 10'(i), 32'(i), 4'hF);
        end
        for (int i = 1; i <= 7; i++) begin
            if (i <= 4) begin
                req_valid[1] = 1'b1;
                req_write[1] = 1'b0;
                req_addr[1]  = 10'(i);
                chk("lat_ready", req_ready[1] === 1'b1, req_ready[1], 1'b1);
            end else begin
                req_valid[1] = 1'b0;
            end
            tick();
            chk("lat_valid", rsp_valid[1] === (i >= 3 && i <= 6), rsp_valid[1], (i >= 3 && i <= 6));
            chk("lat_data", rsp_data[1] === ((i >= 3 && i <= 6) ? 32'(i - 2) : 32'h0),
                rsp_data[1], (i >= 3 && i <= 6) ? 32'(i - 2) : 32'h0);
        end

        rsp_ready[2] = 1'b0;
        do_req(2, 1'b1, 10'd7, 32'hA0A00007, 4'hF);
        do_req(2, 1'b1, 10'd8, 32'hA0A00008, 4'hF);
        do_req(2, 1'b1, 10'd9, 32'hA0A00009, 4'hF);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b0;
        req_addr[2]  = 10'd7;
        chk("bp_ready0", req_ready[2] === 1'b1, req_ready[2], 1'b1);
        tick();
        chk("bp_ready1", req_ready[2] === 1'b1, req_ready[2], 1'b1);
        req_addr[2] = 10'd8;
        tick();
        chk("bp_ready_drop", req_ready[2] === 1'b0, req_ready[2], 1'b0);
        chk("bp_valid", rsp_valid[2] === 1'b1, rsp_valid[2], 1'b1);
        chk("bp_data_a", rsp_data[2] === 32'hA0A00007, rsp_data[2], 32'hA0A00007);
        req_addr[2] = 10'd9;
        tick();
        chk("bp_ready_held", req_ready[2] === 1'b0, req_ready[2], 1'b0);
        chk("bp_data_held", rsp_data[2] === 32'hA0A00007, rsp_data[2], 32'hA0A00007);
        rsp_ready[2] = 1'b1;
        tick();
        chk("bp_data_b", rsp_data[2] === 32'hA0A00008, rsp_data[2], 32'hA0A00008);
        chk("bp_ready_back", req_ready[2] === 1'b1, req_ready[2], 1'b1);
        tick();
        req_valid[2] = 1'b0;
        chk("bp_valid_c", rsp_valid[2] === 1'b1, rsp_valid[2], 1'b1);
        chk("bp_data_c", rsp_data[2] === 32'hA0A00009, rsp_data[2], 32'hA0A00009);
        tick();
        chk("bp_drained", rsp_valid[2] === 1'b0, rsp_valid[2], 1'b0);
        chk("bp_ready_end", req_ready[2] === 1'b1, req_ready[2], 1'b1);

        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 10'd1;
        tick();
        req_addr[1] = 10'd2;
        tick();
        req_valid[1] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", rsp_valid[1] === 1'b0, rsp_valid[1], 1'b0);
        chk("mrst_data", rsp_data[1] === 32'h0, rsp_data[1], 32'h0);
        chk("mrst_ready", req_ready[1] === 1'b1, req_ready[1], 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mrst_no_late_rsp", rsp_valid[1] === 1'b0, rsp_valid[1], 1'b0);
        end
        req_valid[1] = 1'b1;
        req_addr[1]  = 10'd1;
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        chk("mrst_mem_valid", rsp_valid[1] === 1'b1, rsp_valid[1], 1'b1);
        chk("mrst_mem_data", rsp_data[1] === 32'h0, rsp_data[1], 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
